// File: rtl/dpd_pkg.sv
// Shared DPD datapath constants and the per-bank state type used by the feature serializer.
package dpd_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int MEMORY_DEPTH = 5;
  // Vector layout: 2 + 3*(M+1) + 2*M elements for memory depth M
  localparam int FEAT_VEC_DIM = 2 + 3 * (MEMORY_DEPTH + 1) + 2 * MEMORY_DEPTH;
  localparam int FEAT_IDX_W   = $clog2(FEAT_VEC_DIM);

  typedef enum logic [1:0] {
    BANK_EMPTY     = 2'd0,
    BANK_FULL      = 2'd1,
    BANK_STREAMING = 2'd2
  } bank_state_e;

endpackage

// File: rtl/fser_pingpong_bank.sv
// Two-bank register storage for feature vectors: whole-vector write into one bank,
// single-element read mux selected by (bank, index).
module fser_pingpong_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_DIM    = 30,
  parameter int IDX_W      = 5
) (
  input  logic                          clk,
  input  logic                          wr_en_i,
  input  logic                          wr_bank_i,
  input  logic [DATA_WIDTH*VEC_DIM-1:0] vec_i,
  input  logic                          rd_bank_i,
  input  logic [IDX_W-1:0]              rd_idx_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2][VEC_DIM];

  // Contents carry no reset: a bank is only read after its full flag says it was written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < VEC_DIM; k++) begin
        mem_q[wr_bank_i][k] <= vec_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_idx_i];

endmodule

// File: rtl/feature_serializer.sv
// Ping-pong feature-vector serializer: captures whole vectors, streams elements over valid/ready.
// Optional drop counter port/logic enabled by defining FSER_DROP_CNT_EN.
module feature_serializer #(
  parameter int DATA_WIDTH = dpd_pkg::DATA_WIDTH,
  parameter int VEC_DIM    = dpd_pkg::FEAT_VEC_DIM,
  parameter int IDX_W      = dpd_pkg::FEAT_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH*VEC_DIM-1:0] vec_in,
  input  logic                          vec_valid,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         elem_data,
  output logic [IDX_W-1:0]              elem_idx,
  output logic                          elem_valid,
  input  logic                          elem_ready,
  output logic                          elem_last,
  output logic                          busy,
`ifdef FSER_DROP_CNT_EN
  output logic [15:0]                   drop_cnt,
`endif
  output logic                          ovf
);

  import dpd_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_DIM - 1);

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic xfer;
  logic last_xfer;
  logic accept;

  assign elem_valid = (bank_q[rd_ptr_q] != BANK_EMPTY);
  assign xfer       = elem_valid & elem_ready;
  assign last_xfer  = xfer && (idx_q == LAST_IDX);

  // A bank being drained by its final transfer this cycle counts as free for capture.
  assign accept = vec_valid && !flush &&
                  ((bank_q[wr_ptr_q] == BANK_EMPTY) ||
                   (last_xfer && (wr_ptr_q == rd_ptr_q)));

  always_comb begin
    bank_d   = bank_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    ovf_d    = 1'b0;
    if (flush) begin
      bank_d[0] = BANK_EMPTY;
      bank_d[1] = BANK_EMPTY;
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      idx_d     = '0;
    end else begin
      if (bank_q[rd_ptr_q] == BANK_FULL) begin
        bank_d[rd_ptr_q] = BANK_STREAMING;
      end
      if (xfer) begin
        if (last_xfer) begin
          idx_d            = '0;
          bank_d[rd_ptr_q] = BANK_EMPTY;
          rd_ptr_d         = ~rd_ptr_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if (accept) begin
        bank_d[wr_ptr_q] = BANK_FULL;
        wr_ptr_d         = ~wr_ptr_q;
      end
      ovf_d = vec_valid && !accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FSER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Counts alongside the ovf pulse; flush never touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'h0000;
    end else if (ovf_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  fser_pingpong_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_DIM    (VEC_DIM),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_bank_i (wr_ptr_q),
    .vec_i     (vec_in),
    .rd_bank_i (rd_ptr_q),
    .rd_idx_i  (idx_q),
    .rd_data_o (elem_data)
  );

  assign elem_idx  = idx_q;
  assign elem_last = (idx_q == LAST_IDX);
  assign busy      = (bank_q[0] != BANK_EMPTY) || (bank_q[1] != BANK_EMPTY);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_feature_serializer.sv
// Directed self-checking bench for feature_serializer; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_feature_serializer;

  localparam int DW = 16;
  localparam int VD = 30;
  localparam int IW = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DW*VD-1:0]   vec_in = '0;
  logic               vec_valid = 1'b0;
  logic               flush = 1'b0;
  logic [DW-1:0]      elem_data;
  logic [IW-1:0]      elem_idx;
  logic               elem_valid;
  logic               elem_ready = 1'b0;
  logic               elem_last;
  logic               busy;
  logic               ovf;
`ifdef FSER_DROP_CNT_EN
  logic [15:0]        drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  feature_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vec_in     (vec_in),
    .vec_valid  (vec_valid),
    .flush      (flush),
    .elem_data  (elem_data),
    .elem_idx   (elem_idx),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_last  (elem_last),
    .busy       (busy),
`ifdef FSER_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .ovf        (ovf)
  );

  // {valid, idx, last, data}
  logic [22:0] obs;
  logic [22:0] exp;
  assign obs = {elem_valid, elem_idx, elem_last, elem_data};

  function automatic logic [DW*VD-1:0] make_vec(input logic [15:0] base);
    logic [DW*VD-1:0] v;
    for (int k = 0; k < VD; k++) v[k*DW +: DW] = base + 16'(k);
    return v;
  endfunction

  function automatic logic [22:0] elem_exp(input logic [15:0] base, input int k);
    return {1'b1, 5'(k), (k == VD - 1), base + 16'(k)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    if ({elem_valid, elem_idx, elem_last, busy, ovf} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {elem_valid, elem_idx, elem_last, busy, ovf}, 9'd0);
    end
    checks++;
`ifdef FSER_DROP_CNT_EN
    if (drop_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt);
    end
    checks++;
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    elem_ready = 1'b1;
    if (elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_valid: got %b expected 0", elem_valid);
    end
    checks++;
    vec_in = make_vec(16'h0100);
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    for (int k = 0; k < VD; k++) begin
      exp = elem_exp(16'h0100, k);
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_elem%0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      $display("single xfer idx=%0d data=%h last=%b", elem_idx, elem_data, elem_last);
      step();
    end
    if ({elem_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got valid/busy %b expected 00", {elem_valid, busy});
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int k = 0;
    int cyc = 0;
    elem_ready = 1'b0;
    vec_in = make_vec(16'h0200);
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    while (k < VD && cyc < 100) begin
      exp = elem_exp(16'h0200, k);
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %h expected %h", cyc, obs, exp);
      end
      checks++;
      elem_ready = (cyc % 2 == 0);
      if (elem_ready) begin
        $display("bp xfer idx=%0d data=%h", elem_idx, elem_data);
        k++;
      end
      cyc++;
      step();
    end
    if (k != VD) begin
      errors++;
      $display("FAIL bp_timeout: got %0d transfers expected %0d", k, VD);
    end
    checks++;
    elem_ready = 1'b1;
    if (elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_valid: got %b expected 0", elem_valid);
    end
    checks++;
  endtask

  task automatic test_overflow();
    logic [15:0] bases [3];
    logic        ovf_exp [3];
    bases = '{16'h0A00, 16'h0B00, 16'h0C00};
    ovf_exp = '{1'b0, 1'b0, 1'b1};
    elem_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      vec_in = make_vec(bases[p]);
      vec_valid = 1'b1;
      step();
      if (ovf !== ovf_exp[p]) begin
        errors++;
        $display("FAIL ovf_pulse%0d: got %b expected %b", p, ovf, ovf_exp[p]);
      end
      checks++;
    end
    vec_valid = 1'b0;
    step();
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_single_pulse: got %b expected 0", ovf);
    end
    checks++;
`ifdef FSER_DROP_CNT_EN
    if (drop_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL ovf_drop_cnt: got %h expected 0001", drop_cnt);
    end
    checks++;
`endif
    elem_ready = 1'b1;
    for (int k = 0; k < 2 * VD; k++) begin
      exp = elem_exp((k < VD) ? 16'h0A00 : 16'h0B00, k % VD);
      if (obs !== exp) begin
        errors++;
        $display("FAIL ovf_stream%0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      $display("ovf xfer idx=%0d data=%h", elem_idx, elem_data);
      step();
    end
    if ({elem_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_done: got valid/busy %b expected 00", {elem_valid, busy});
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    elem_ready = 1'b0;
    vec_in = make_vec(16'h1A00);
    vec_valid = 1'b1;
    step();
    vec_in = make_vec(16'h1B00);
    step();
    vec_valid = 1'b0;
    elem_ready = 1'b1;
    for (int k = 0; k < 3 * VD; k++) begin
      exp = elem_exp((k < VD) ? 16'h1A00 : (k < 2 * VD) ? 16'h1B00 : 16'h1C00, k % VD);
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_stream%0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      if (ovf !== 1'b0) begin
        errors++;
        $display("FAIL simul_ovf%0d: got %b expected 0", k, ovf);
      end
      checks++;
      $display("simul xfer idx=%0d data=%h", elem_idx, elem_data);
      vec_valid = (k == VD - 1);
      vec_in = make_vec(16'h1C00);
      step();
    end
    vec_valid = 1'b0;
    if ({elem_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL simul_done: got valid/busy %b expected 00", {elem_valid, busy});
    end
    checks++;
  endtask

  task automatic test_flush();
    elem_ready = 1'b1;
    vec_in = make_vec(16'h2D00);
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    exp = elem_exp(16'h2D00, 5);
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_pre: got %h expected %h", obs, exp);
    end
    checks++;
    flush = 1'b1;
    vec_valid = 1'b1;
    vec_in = make_vec(16'h2E00);
    step();
    flush = 1'b0;
    vec_valid = 1'b0;
    if ({elem_valid, busy, ovf, elem_idx} !== 8'd0) begin
      errors++;
      $display("FAIL flush_after: got valid/busy/ovf/idx %b expected 0", {elem_valid, busy, ovf, elem_idx});
    end
    checks++;
    step();
    if ({elem_valid, ovf} !== 2'b00) begin
      errors++;
      $display("FAIL flush_discard: got valid/ovf %b expected 00", {elem_valid, ovf});
    end
    checks++;
`ifdef FSER_DROP_CNT_EN
    if (drop_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL flush_drop_cnt: got %h expected 0001", drop_cnt);
    end
    checks++;
`endif
    vec_in = make_vec(16'h2F00);
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    for (int k = 0; k < VD; k++) begin
      exp = elem_exp(16'h2F00, k);
      if (obs !== exp) begin
        errors++;
        $display("FAIL flush_next%0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      $display("flush xfer idx=%0d data=%h", elem_idx, elem_data);
      step();
    end
    if ({elem_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_done: got valid/busy %b expected 00", {elem_valid, busy});
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
